// File: rtl/bp_ghist_index.sv
// Global-history branch predictor index generator with an in-order checkpoint
// ring. It keeps the speculative history used to form table read indices, and
// the committed history used to recover on flush. It also issues the table
// update writes when branches resolve.
module bp_ghist_index #(
    parameter int unsigned IDX_LEN    = 8,
    parameter int unsigned HIST_LEN   = 8,
    parameter int unsigned CKPT_DEPTH = 8,
    localparam int unsigned TAG_W     = $clog2(CKPT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_predValid,
    input  logic [31:0]        IN_predPC,
    output logic               OUT_predReady,
    output logic               OUT_readValid,
    output logic [IDX_LEN-1:0] OUT_readAddr,
    input  logic               IN_tableTaken,
    output logic               OUT_allocValid,
    output logic [TAG_W-1:0]   OUT_allocTag,
    input  logic               IN_resValid,
    input  logic [TAG_W-1:0]   IN_resTag,
    input  logic               IN_resTaken,
    input  logic               IN_resMispred,
    input  logic               IN_flush,
    output logic               OUT_writeEn,
    output logic [IDX_LEN-1:0] OUT_writeAddr,
    output logic               OUT_writeTaken,
    output logic               OUT_writeInit
);

    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [IDX_LEN-1:0]  idx;
        logic [HIST_LEN-1:0] prev_hist;
        logic                pred_taken;
    } ckpt_t;

    ckpt_t               ring_q [CKPT_DEPTH];
    ckpt_t               head_entry;

    logic [HIST_LEN-1:0] spec_hist_q,   spec_hist_d;
    logic [HIST_LEN-1:0] commit_hist_q, commit_hist_d;
    logic [TAG_W-1:0]    head_q,        head_d;
    logic [TAG_W-1:0]    tail_q,        tail_d;
    logic [CNT_W-1:0]    count_q,       count_d;
    logic                in_flight_q,   in_flight_d;
    logic [IDX_LEN-1:0]  flight_idx_q,  flight_idx_d;

    logic                write_en_q;
    logic [IDX_LEN-1:0]  write_addr_q;
    logic                write_taken_q;

    logic [IDX_LEN-1:0]  read_addr;
    logic [OCC_W-1:0]    occupancy;
    logic                pred_ready;
    logic                lookup_acc;
    logic                res_acc;
    logic                mispred;
    logic                flush_acc;
    logic                alloc;

    // PC bits outside the index field and the stored prediction bit are not consumed here.
    logic                unused_bits;
    assign unused_bits = ^{IN_predPC[31:IDX_LEN+1], IN_predPC[0], head_entry.pred_taken};

    // Lookup/resolve handshakes; flush and mispredict both suppress the pending allocation.
    always_comb begin
        head_entry = ring_q[head_q];
        read_addr  = IN_predPC[IDX_LEN:1] ^ IDX_LEN'(spec_hist_q);
        occupancy  = OCC_W'(count_q) + OCC_W'(in_flight_q);
        flush_acc  = rst & IN_flush;
        pred_ready = rst & ~IN_flush & (occupancy < OCC_W'(CKPT_DEPTH));
        lookup_acc = IN_predValid & pred_ready;
        res_acc    = rst & IN_resValid & (count_q != '0) & (IN_resTag == head_q);
        mispred    = res_acc & IN_resMispred;
        alloc      = rst & in_flight_q & ~mispred & ~flush_acc;
    end

    // Next-state: allocate, pop, then mispredict recovery, then flush has the final say.
    always_comb begin
        spec_hist_d   = spec_hist_q;
        commit_hist_d = commit_hist_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q + CNT_W'(alloc) - CNT_W'(res_acc);
        in_flight_d   = lookup_acc;
        flight_idx_d  = lookup_acc ? read_addr : flight_idx_q;

        if (res_acc) begin
            commit_hist_d = HIST_LEN'({commit_hist_q, IN_resTaken});
            head_d        = head_q + TAG_W'(1);
        end
        if (alloc) begin
            tail_d      = tail_q + TAG_W'(1);
            spec_hist_d = HIST_LEN'({spec_hist_q, IN_tableTaken});
        end
        if (mispred) begin
            spec_hist_d = HIST_LEN'({head_entry.prev_hist, IN_resTaken});
            count_d     = '0;
            tail_d      = head_q + TAG_W'(1);
            in_flight_d = 1'b0;
        end
        if (flush_acc) begin
            spec_hist_d = commit_hist_d;
            count_d     = '0;
            head_d      = tail_d;
            in_flight_d = 1'b0;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            spec_hist_q   <= '0;
            commit_hist_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            in_flight_q   <= 1'b0;
            flight_idx_q  <= '0;
        end else begin
            spec_hist_q   <= spec_hist_d;
            commit_hist_q <= commit_hist_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            in_flight_q   <= in_flight_d;
            flight_idx_q  <= flight_idx_d;
        end
    end

    // Checkpoint storage; entries are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ring_q[tail_q] <= '{idx: flight_idx_q, prev_hist: spec_hist_q, pred_taken: IN_tableTaken};
        end
    end

    // Table update port, one cycle after an accepted resolution.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_en_q    <= 1'b0;
            write_addr_q  <= '0;
            write_taken_q <= 1'b0;
        end else begin
            write_en_q <= res_acc;
            if (res_acc) begin
                write_addr_q  <= head_entry.idx;
                write_taken_q <= IN_resTaken;
            end
        end
    end

    // Output mapping.
    always_comb begin
        OUT_predReady  = pred_ready;
        OUT_readValid  = lookup_acc;
        OUT_readAddr   = read_addr;
        OUT_allocValid = alloc;
        OUT_allocTag   = tail_q;
        OUT_writeEn    = write_en_q;
        OUT_writeAddr  = write_addr_q;
        OUT_writeTaken = write_taken_q;
        OUT_writeInit  = 1'b0;
    end

endmodule

// File: doc/bp_ghist_index.md
BP_GHIST_INDEX -- requirements
Module: bp_ghist_index

Interface
REQ-001 Parameter IDX_LEN, default 8: width of the prediction-table index.
REQ-002 Parameter HIST_LEN, default 8: global history length; SHALL be <= IDX_LEN.
REQ-003 Parameter CKPT_DEPTH, default 8: checkpoint ring entries; power of two; TAG_W = log2(CKPT_DEPTH).
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 IN_predValid  in  1  fetch requests a lookup this cycle.
REQ-007 IN_predPC  in  32  branch PC; index bits PC[IDX_LEN:1].
REQ-008 OUT_predReady  out  1  lookup can be accepted this cycle.
REQ-009 OUT_readValid  out  1  table read enable; = IN_predValid & OUT_predReady.
REQ-010 OUT_readAddr  out  IDX_LEN  table read index (combinational).
REQ-011 IN_tableTaken  in  1  table prediction, valid the cycle after an accepted lookup.
REQ-012 OUT_allocValid  out  1  checkpoint allocated this cycle.
REQ-013 OUT_allocTag  out  TAG_W  tag of the allocated checkpoint.
REQ-014 IN_resValid  in  1  branch resolution.
REQ-015 IN_resTag  in  TAG_W  tag being resolved.
REQ-016 IN_resTaken  in  1  actual direction.
REQ-017 IN_resMispred  in  1  prediction was wrong.
REQ-018 IN_flush  in  1  discard all speculative state.
REQ-019 OUT_writeEn, OUT_writeAddr[IDX_LEN], OUT_writeTaken, OUT_writeInit  out  table update port, registered.

Function
REQ-020 OUT_readAddr SHALL equal PC[IDX_LEN:1] XOR zero-extended specHist.
REQ-021 Accepted lookup in cycle N SHALL set inFlight, latching index; in N+1 a checkpoint {index, prevHist=specHist, predTaken=IN_tableTaken} SHALL be written at tail; OUT_allocValid=1, OUT_allocTag=tail; tail+1; specHist <= {specHist[HIST_LEN-2:0], IN_tableTaken}.
REQ-022 OUT_predReady SHALL be 1 iff out of reset and (count + inFlight) < CKPT_DEPTH; back-to-back lookups allowed (second uses pre-shift history).
REQ-023 Resolution SHALL be in order: accepted only if IN_resValid, count>0, IN_resTag==head; otherwise no state change.
REQ-024 Accepted resolution SHALL pop head, set commitHist <= {commitHist[HIST_LEN-2:0], IN_resTaken}, and next cycle drive OUT_writeEn=1, OUT_writeAddr=stored index, OUT_writeTaken=IN_resTaken.
REQ-025 OUT_writeInit SHALL be constant 0; OUT_writeEn SHALL be 0 in cycles with no accepted resolution.
REQ-026 Accepted resolution with IN_resMispred SHALL: specHist <= {head.prevHist[HIST_LEN-2:0], IN_resTaken}; free all entries (count=0, tail=head+1); cancel inFlight (no allocation next cycle).
REQ-027 Mispredict and allocation same cycle: mispredict wins; allocation suppressed, OUT_allocValid=0.
REQ-028 Non-mispredict resolve and allocation same cycle: both occur; count unchanged.
REQ-029 IN_flush SHALL set specHist <= commitHist (after any same-cycle accepted resolve), count=0, head=tail, inFlight=0; OUT_predReady=0 that cycle; same-cycle accepted resolve still produces its table write.
REQ-030 Pointers SHALL wrap modulo CKPT_DEPTH; count width TAG_W+1; full when count==CKPT_DEPTH.

Reset
REQ-031 On clk with rst=0: specHist=0, commitHist=0, head=tail=0, count=0, inFlight=0, OUT_writeEn=0, OUT_writeAddr=0, OUT_writeTaken=0, OUT_allocValid=0.
REQ-032 While rst=0: OUT_predReady=0, OUT_readValid=0; resolutions and flushes ignored.
REQ-033 Reset asserted mid-operation SHALL discard in-flight lookup and all checkpoints with no table write issued.

Verification
REQ-034 After reset, PC=0x0000_0104, hist=0 -> OUT_readAddr=0x82; tableTaken=1 next cycle -> allocTag=0, specHist=0x01.
REQ-035 8 lookups, tableTaken alternating 1,0 -> specHist=0xAA, predReady=0 once 8 outstanding; 9th request not accepted.
REQ-036 Resolve tag 0 taken, no mispredict -> next cycle writeEn=1, writeAddr=tag-0 index, writeTaken=1; commitHist=0x01.
REQ-037 3 allocations, resolve tag 0 mispred with resTaken=0, prevHist=0x00 -> specHist=0x00, count=0, next allocTag=1.
REQ-038 Resolve with tag != head, or on empty ring -> no write, no state change.
REQ-039 Flush with 4 outstanding, commitHist=0x05 -> specHist=0x05, count=0, lookup in flight produces no allocation.
